tw75_addr_seq: RTL and testbench
================================

Name: tw75_addr_seq

Overview:
Address sequencer for the 75-entry twiddle ROM (W75^k, addr 0..74) used by the 75-point mixed-radix DFT stages. For a configured stage of n1 rows × n2 columns, it emits addr = (r·c·step) mod 75 in row-major order. It uses incremental modular adds, with no multipliers.
Output uses a valid/ready handshake toward the butterfly datapath. A delayed "twiddle valid" strobe is aligned to the ROM's optional output register.

Parameters:
N, 75, twiddle table size (modulus)
ADDR_W, 11, ROM address width
TW_FF, 0, ROM output-register latency to match (0 or 1)

Ports:
clk  in  1  master clock
rst  in  1  synchronous active-high reset
start  in  1  start pulse; sampled only in IDLE
n1  in  7  row count (1..75), latched at start
n2  in  7  column count (1..75), latched at start
step  in  7  twiddle stride (0..74), latched at start
busy  out  1  high whenever state != IDLE
cfg_err  out  1  one-cycle pulse: start with n1==0, n2==0 or step>=75
addr_out  out  ADDR_W  twiddle address, zero-extended, always < 75
addr_vld  out  1  addr_out valid
addr_rdy  in  1  consumer ready
addr_last  out  1  marks final address of frame (with addr_vld)
tw_vld  out  1  ROM data for an accepted address is valid this cycle
tw_last  out  1  tw_vld for the final address
done  out  1  one-cycle pulse after frame completes

Behaviour:
- Reset: state=IDLE. All outputs 0, counters/accumulators 0. Applies mid-frame: the frame is aborted, with no done and no further tw_vld (the TW_FF pipeline register is also cleared).
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start with a valid config: latch n1/n2/step; r=0, c=0, acc=0, inc=0.
  - IDLE stays IDLE on start with an invalid config: cfg_err=1 for that cycle.
  - RUN→DONE on the handshake (addr_vld&addr_rdy) where addr_last=1.
  - DONE→IDLE unconditionally; done=1 only while in DONE.
  - start is ignored outside IDLE.
- Latency: start at cycle t → addr_vld=1 and addr_out=0 at t+1. addr_vld stays 1 throughout RUN (no bubbles). addr_out/addr_last hold stable while addr_rdy=0.
- Advance on handshake only:
  - If c<n2-1: c++, acc = acc+inc, subtract 75 if ≥75.
  - Else: c=0, r++, acc=0, inc = inc+step, subtract 75 if ≥75.
  - Sums are < 150, so 8-bit add plus one conditional subtract.
- addr_out = acc. addr_last = (r==n1-1)&&(c==n2-1).
- Frame length is exactly n1·n2 handshakes. n1=n2=1 → single address 0 with addr_last=1.
- tw_vld/tw_last:
  - TW_FF=0: tw_vld = addr_vld&addr_rdy, tw_last = that & addr_last (combinational).
  - TW_FF=1: the same signals registered one cycle.
- done pulses the cycle after the last handshake, regardless of TW_FF. With TW_FF=1, tw_last coincides with done.
- busy=1 in RUN and DONE. A new start is accepted the cycle after done, at the earliest.

Test Plan:
1. rst, then start n1=3,n2=25,step=1, addr_rdy=1 → 75 addrs: row0 all 0; row1 0..24; row2 0,2,..,48. addr_last on the 75th. done at t+76. busy spans t+1..t+76.
2. n1=3,n2=25,step=2 → row2,c=24 gives (2·24·2) mod 75 = 21. The row2 sequence wraps after 72 (c=18) to 1. Never ≥75.
3. n1=15,n2=5,step=1 with addr_rdy toggling 1,0,0,1… → addr_out/addr_last stable while stalled. Final addr = 56 (14·4). Exactly 75 tw_vld pulses.
4. TW_FF=1, n1=n2=1,step=0 → one addr 0 with addr_last. tw_vld/tw_last one cycle after the handshake, coincident with done.
5. start with n2=0, then with step=75 → cfg_err pulse each time, busy stays 0, no addr_vld.
6. Assert rst mid-frame at r=1,c=7 (TW_FF=1) → next cycle all outputs 0, no done. A fresh start restarts at addr 0. start pulses during RUN are ignored.

Source files
------------

// File: rtl/tw75_addr_seq.sv
// tw75_addr_seq
// Address sequencer for the 75-entry twiddle ROM (W75^k). For a stage of
// n1 rows by n2 columns it emits addr = (r*c*step) mod 75 in row-major order.
// The address is built from modular adds only; there are no multipliers.
//
// Ports:
//   i_clk        master clock
//   i_rst        synchronous active-high reset (aborts any frame)
//   i_start      start pulse, sampled only in IDLE
//   i_n1, i_n2   row / column counts (1..75), latched at start
//   i_step       twiddle stride (0..74), latched at start
//   o_busy       high in RUN and DONE
//   o_cfg_err    pulse when start arrives with an invalid configuration
//   o_addr_out   twiddle address (zero-extended, always < 75)
//   o_addr_vld   address valid (high for the whole of RUN)
//   i_addr_rdy   consumer ready
//   o_addr_last  final address of the frame
//   o_tw_vld     ROM data for an accepted address is valid this cycle
//   o_tw_last    o_tw_vld for the final address
//   o_done       one-cycle pulse after the frame completes
//
// state | meaning
// IDLE  | waiting for a valid start
// RUN   | presenting addresses, advancing on each handshake
// DONE  | one-cycle completion pulse, returns to IDLE

module tw75_addr_seq #(
  parameter int N      = 75,
  parameter int ADDR_W = 11,
  parameter int TW_FF  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [6:0]        i_n1,
  input  logic [6:0]        i_n2,
  input  logic [6:0]        i_step,
  output logic              o_busy,
  output logic              o_cfg_err,
  output logic [ADDR_W-1:0] o_addr_out,
  output logic              o_addr_vld,
  input  logic              i_addr_rdy,
  output logic              o_addr_last,
  output logic              o_tw_vld,
  output logic              o_tw_last,
  output logic              o_done
);

  localparam logic [7:0] MOD = 8'(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t     r_state;
  logic [6:0] r_n1;
  logic [6:0] r_n2;
  logic [6:0] r_step;
  logic [6:0] r_r;
  logic [6:0] r_c;
  logic [6:0] r_acc;
  logic [6:0] r_inc;

  logic       w_cfg_ok;
  logic       w_hs;
  logic       w_col_end;
  logic       w_row_end;
  logic [7:0] w_acc_sum;
  logic [7:0] w_acc_nxt;
  logic [7:0] w_inc_sum;
  logic [7:0] w_inc_nxt;

  assign w_cfg_ok  = (i_n1 != 7'd0) && (i_n2 != 7'd0) && ({1'b0, i_step} < MOD);
  assign w_hs      = (r_state == S_RUN) && i_addr_rdy;
  assign w_col_end = (r_c == r_n2 - 7'd1);
  assign w_row_end = (r_r == r_n1 - 7'd1);

  // Both operands are < 75, so one conditional subtract reduces the sum.
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_acc_nxt = (w_acc_sum >= MOD) ? w_acc_sum - MOD : w_acc_sum;
  assign w_inc_sum = {1'b0, r_inc} + {1'b0, r_step};
  assign w_inc_nxt = (w_inc_sum >= MOD) ? w_inc_sum - MOD : w_inc_sum;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_n1    <= '0;
      r_n2    <= '0;
      r_step  <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_acc   <= '0;
      r_inc   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && w_cfg_ok) begin
            r_n1    <= i_n1;
            r_n2    <= i_n2;
            r_step  <= i_step;
            r_r     <= '0;
            r_c     <= '0;
            r_acc   <= '0;
            r_inc   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_hs) begin
            if (w_col_end && w_row_end) begin
              r_state <= S_DONE;
            end
            // inc tracks r*step for the next row; acc tracks r*c*step.
            if (!w_col_end) begin
              r_c   <= r_c + 7'd1;
              r_acc <= w_acc_nxt[6:0];
            end else begin
              r_c   <= '0;
              r_r   <= r_r + 7'd1;
              r_acc <= '0;
              r_inc <= w_inc_nxt[6:0];
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_cfg_err   = !i_rst && (r_state == S_IDLE) && i_start && !w_cfg_ok;
  assign o_addr_vld  = (r_state == S_RUN);
  assign o_addr_last = o_addr_vld && w_col_end && w_row_end;
  assign o_done      = (r_state == S_DONE);
  assign o_addr_out  = {{(ADDR_W-7){1'b0}}, r_acc};

  generate
    if (TW_FF == 0) begin : g_tw_comb
      assign o_tw_vld  = w_hs;
      assign o_tw_last = w_hs && o_addr_last;
    end else begin : g_tw_reg
      logic r_tw_vld;
      logic r_tw_last;
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_tw_vld  <= 1'b0;
          r_tw_last <= 1'b0;
        end else begin
          r_tw_vld  <= w_hs;
          r_tw_last <= w_hs && o_addr_last;
        end
      end
      assign o_tw_vld  = r_tw_vld;
      assign o_tw_last = r_tw_last;
    end
  endgenerate

endmodule

// File: tb/tb_tw75_addr_seq.sv
// Bench for tw75_addr_seq: two instances (TW_FF=0 and TW_FF=1) share the same
// stimulus. Expected addresses come from (r*c*step) mod 75 computed directly.

module tb_tw75_addr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  n1_s, n2_s, step_s;
  logic        rdy;

  logic        busy0, cfg0, vld0, last0, twv0, twl0, done0;
  logic        busy1, cfg1, vld1, last1, twv1, twl1, done1;
  logic [10:0] addr0, addr1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tw75_addr_seq #(.N(75), .ADDR_W(11), .TW_FF(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_n1(n1_s), .i_n2(n2_s),
    .i_step(step_s), .o_busy(busy0), .o_cfg_err(cfg0), .o_addr_out(addr0),
    .o_addr_vld(vld0), .i_addr_rdy(rdy), .o_addr_last(last0),
    .o_tw_vld(twv0), .o_tw_last(twl0), .o_done(done0)
  );

  tw75_addr_seq #(.N(75), .ADDR_W(11), .TW_FF(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_n1(n1_s), .i_n2(n2_s),
    .i_step(step_s), .o_busy(busy1), .o_cfg_err(cfg1), .o_addr_out(addr1),
    .o_addr_vld(vld1), .i_addr_rdy(rdy), .o_addr_last(last1),
    .o_tw_vld(twv1), .o_tw_last(twl1), .o_done(done1)
  );

  // Observed flags, ordered {busy, cfg_err, addr_vld, addr_last, tw_vld, tw_last, done}
  wire [6:0] obs0 = {busy0, cfg0, vld0, last0, twv0, twl0, done0};
  wire [6:0] obs1 = {busy1, cfg1, vld1, last1, twv1, twl1, done1};

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rdy = 1'b0; n1_s = '0; n2_s = '0; step_s = '0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs0 !== 7'd0 || addr0 !== 11'd0) begin
      fails++; $display("FAIL reset_dut0 flags=%b addr=%0d exp flags=0 addr=0", obs0, addr0);
    end
    tests++;
    if (obs1 !== 7'd0 || addr1 !== 11'd0) begin
      fails++; $display("FAIL reset_dut1 flags=%b addr=%0d exp flags=0 addr=0", obs1, addr1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // pct >= 0: ready probability in percent; pct < 0: ready pattern 1,0,0,1,0,0...
  task automatic test_frame(input int n1, input int n2, input int step,
                            input int pct, input bit chk_len, input bit noise);
    int q[$];
    int cyc, tw0, tw1;
    bit prev_hs, prev_last, last, r_now;
    logic [6:0] e0, e1;
    for (int r = 0; r < n1; r++)
      for (int c = 0; c < n2; c++)
        q.push_back((r * c * step) % 75);

    start = 1'b1; n1_s = 7'(n1); n2_s = 7'(n2); step_s = 7'(step); rdy = 1'b0;
    #1;
    tests++;
    if (obs0 !== 7'd0 || obs1 !== 7'd0) begin
      fails++; $display("FAIL start_cycle flags0=%b flags1=%b exp 0", obs0, obs1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    prev_hs = 1'b0; prev_last = 1'b0; cyc = 0; tw0 = 0; tw1 = 0;

    while (q.size() > 0 && cyc < 4000) begin
      r_now = (pct < 0) ? (cyc % 3 == 0) : ($urandom_range(99) < pct);
      rdy = r_now;
      if (noise) begin
        start  = 1'($urandom_range(1));
        n1_s   = 7'($urandom_range(127));
        n2_s   = 7'($urandom_range(127));
        step_s = 7'($urandom_range(127));
      end
      #1;
      last = (q.size() == 1);
      e0 = {1'b1, 1'b0, 1'b1, last, r_now, r_now & last, 1'b0};
      e1 = {1'b1, 1'b0, 1'b1, last, prev_hs, prev_last, 1'b0};
      tests++;
      if (addr0 !== 11'(q[0]) || addr1 !== 11'(q[0])) begin
        fails++;
        $display("FAIL addr n1=%0d n2=%0d step=%0d idx=%0d got0=%0d got1=%0d exp=%0d",
                 n1, n2, step, n1 * n2 - q.size(), addr0, addr1, q[0]);
      end
      tests++;
      if (obs0 !== e0) begin
        fails++; $display("FAIL run_flags0 cyc=%0d got=%b exp=%b", cyc, obs0, e0);
      end
      tests++;
      if (obs1 !== e1) begin
        fails++; $display("FAIL run_flags1 cyc=%0d got=%b exp=%b", cyc, obs1, e1);
      end
      if (twv0) tw0++;
      if (twv1) tw1++;
      prev_hs   = r_now;
      prev_last = r_now & last;
      if (r_now) void'(q.pop_front());
      cyc++;
      @(posedge clk); #1;
    end

    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL frame_timeout remaining=%0d exp 0", q.size());
    end

    start = 1'b0; rdy = 1'($urandom_range(1));
    #1;
    tests++;
    if (obs0 !== 7'b1000001) begin
      fails++; $display("FAIL done_cycle0 got=%b exp=%b", obs0, 7'b1000001);
    end
    tests++;
    if (obs1 !== 7'b1000111) begin
      fails++; $display("FAIL done_cycle1 got=%b exp=%b", obs1, 7'b1000111);
    end
    if (twv1) tw1++;
    @(posedge clk); #1;
    tests++;
    if (obs0 !== 7'd0 || obs1 !== 7'd0) begin
      fails++; $display("FAIL after_done flags0=%b flags1=%b exp 0", obs0, obs1);
    end
    tests++;
    if (tw0 != n1 * n2 || tw1 != n1 * n2) begin
      fails++; $display("FAIL tw_count got0=%0d got1=%0d exp=%0d", tw0, tw1, n1 * n2);
    end
    if (chk_len) begin
      tests++;
      if (cyc != n1 * n2) begin
        fails++; $display("FAIL frame_len got=%0d exp=%0d", cyc, n1 * n2);
      end
    end
  endtask

  task automatic test_cfg_err();
    int bad_n1[3]   = '{3, 0, 5};
    int bad_n2[3]   = '{0, 4, 5};
    int bad_step[3] = '{1, 2, 75};
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; rdy = 1'b1;
      if (i < 3) begin
        n1_s = 7'(bad_n1[i]); n2_s = 7'(bad_n2[i]); step_s = 7'(bad_step[i]);
      end else begin
        n1_s = 7'd2; n2_s = 7'd2; step_s = 7'($urandom_range(127, 76));
      end
      #1;
      tests++;
      if (obs0 !== 7'b0100000 || obs1 !== 7'b0100000) begin
        fails++; $display("FAIL cfg_err_pulse case=%0d got0=%b got1=%b exp=%b", i, obs0, obs1, 7'b0100000);
      end
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      tests++;
      if (obs0 !== 7'd0 || obs1 !== 7'd0) begin
        fails++; $display("FAIL cfg_err_idle case=%0d got0=%b got1=%b exp 0", i, obs0, obs1);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midframe();
    start = 1'b1; n1_s = 7'd3; n2_s = 7'd10; step_s = 7'd4; rdy = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (17) begin
      @(posedge clk); #1;
    end
    // now at r=1, c=7: address (1*7*4) mod 75 = 28
    tests++;
    if (addr0 !== 11'd28 || addr1 !== 11'd28) begin
      fails++; $display("FAIL midframe_addr got0=%0d got1=%0d exp=28", addr0, addr1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (obs0 !== 7'd0 || obs1 !== 7'd0 || addr0 !== 11'd0 || addr1 !== 11'd0) begin
      fails++; $display("FAIL midframe_reset flags0=%b flags1=%b addr0=%0d addr1=%0d exp 0", obs0, obs1, addr0, addr1);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if (obs0 !== 7'd0 || obs1 !== 7'd0) begin
        fails++; $display("FAIL post_reset_quiet cyc=%0d got0=%b got1=%b exp 0", i, obs0, obs1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame(3, 25, 1, 100, 1'b1, 1'b0);
    test_frame(3, 25, 2, 100, 1'b1, 1'b0);
    test_frame(15, 5, 1, -1, 1'b0, 1'b0);
    test_frame(1, 1, 0, 100, 1'b1, 1'b0);
    test_cfg_err();
    test_reset_midframe();
    test_frame(3, 10, 4, 60, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++)
      test_frame($urandom_range(12, 1), $urandom_range(12, 1), $urandom_range(74),
                 $urandom_range(100, 30), 1'b0, 1'b1);
    test_frame(75, 1, 74, 100, 1'b1, 1'b0);
    test_frame(1, 75, 74, 100, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
